alu_share_arbiter: RTL

Shares one combinational ALU between two requesters, e.g. the execute stage (port 0) and the address/branch unit (port 1). Each requester uses a valid/ready request channel and a valid/ready response channel. The arbiter grants at most one request per cycle, with round-robin fairness, and drives the shared ALU operands. It captures the ALU result and flags into a one-entry response buffer per requester, so every response returns on its own port in order.

---
 rtl/alu_share_arbiter_if.sv | 47 ++++
 rtl/alu_share_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/alu_share_arbiter_if.sv
// Request/response/ALU bundle shared by the two requesters and the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_share_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4,
  parameter int FLAG_W = 3
);
  logic              req0_valid;
  logic              req1_valid;
  logic              req0_ready;
  logic              req1_ready;
  logic [WIDTH-1:0]  req0_a;
  logic [WIDTH-1:0]  req0_b;
  logic [WIDTH-1:0]  req1_a;
  logic [WIDTH-1:0]  req1_b;
  logic [CTRL_W-1:0] req0_ctrl;
  logic [CTRL_W-1:0] req1_ctrl;

  logic              rsp0_valid;
  logic              rsp1_valid;
  logic              rsp0_ready;
  logic              rsp1_ready;
  logic [WIDTH-1:0]  rsp0_out;
  logic [WIDTH-1:0]  rsp1_out;
  logic [FLAG_W-1:0] rsp0_flags;
  logic [FLAG_W-1:0] rsp1_flags;

  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]  alu_out;
  logic [FLAG_W-1:0] alu_flags;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_ctrl, req1_ctrl, rsp0_ready, rsp1_ready, alu_out, alu_flags,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_out, rsp1_out,
           rsp0_flags, rsp1_flags, alu_a, alu_b, alu_ctrl
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_ctrl, req1_ctrl, rsp0_ready, rsp1_ready, alu_out, alu_flags,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_out, rsp1_out,
           rsp0_flags, rsp1_flags, alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters,
// with a one-entry result buffer per requester.
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4,
  parameter int FLAG_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus
);

  // last_grant_q: 0 = port 0 was granted last, 1 = port 1 was granted last
  logic              last_grant_q, last_grant_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0]  rsp0_out_q, rsp0_out_d;
  logic [WIDTH-1:0]  rsp1_out_q, rsp1_out_d;
  logic [FLAG_W-1:0] rsp0_flags_q, rsp0_flags_d;
  logic [FLAG_W-1:0] rsp1_flags_q, rsp1_flags_d;

  logic elig0, elig1;
  logic grant0, grant1;

  // Grants are masked while reset is asserted so every output reads zero.
  always_comb begin
    elig0  = rst_n & bus.req0_valid & (~rsp0_valid_q | bus.rsp0_ready);
    elig1  = rst_n & bus.req1_valid & (~rsp1_valid_q | bus.rsp1_ready);
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      grant0 = last_grant_q;
      grant1 = ~last_grant_q;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  always_comb begin
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    bus.alu_ctrl = '0;
    if (grant0) begin
      bus.alu_a    = bus.req0_a;
      bus.alu_b    = bus.req0_b;
      bus.alu_ctrl = bus.req0_ctrl;
    end else if (grant1) begin
      bus.alu_a    = bus.req1_a;
      bus.alu_b    = bus.req1_b;
      bus.alu_ctrl = bus.req1_ctrl;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp0_out_d   = rsp0_out_q;
    rsp1_out_d   = rsp1_out_q;
    rsp0_flags_d = rsp0_flags_q;
    rsp1_flags_d = rsp1_flags_q;

    if (grant0) begin
      last_grant_d = 1'b0;
    end else if (grant1) begin
      last_grant_d = 1'b1;
    end

    // A grant also covers drain-and-refill: the buffer stays valid.
    if (grant0) begin
      rsp0_valid_d = 1'b1;
      rsp0_out_d   = bus.alu_out;
      rsp0_flags_d = bus.alu_flags;
    end else if (rsp0_valid_q && bus.rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end

    if (grant1) begin
      rsp1_valid_d = 1'b1;
      rsp1_out_d   = bus.alu_out;
      rsp1_flags_d = bus.alu_flags;
    end else if (rsp1_valid_q && bus.rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_out_q   <= '0;
      rsp1_out_q   <= '0;
      rsp0_flags_q <= '0;
      rsp1_flags_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_out_q   <= rsp0_out_d;
      rsp1_out_q   <= rsp1_out_d;
      rsp0_flags_q <= rsp0_flags_d;
      rsp1_flags_q <= rsp1_flags_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_out   = rsp0_out_q;
  assign bus.rsp1_out   = rsp1_out_q;
  assign bus.rsp0_flags = rsp0_flags_q;
  assign bus.rsp1_flags = rsp1_flags_q;

endmodule
